// File: rtl/freq_meter.sv
`timescale 1ns/1ps
// freq_meter: counts rising edges of a slow asynchronous square wave over a
// fixed gate window of GATE_CYCLES clkin cycles and latches the count.
// Windows run back to back while en=1. Each completed window has one dead
// cycle (LATCH) in which edges are not counted.
//
// Ports:
//   clkin      system clock, rising edge
//   rst        asynchronous active-low reset
//   en         1 = run gate windows continuously, 0 = stop / abort window
//   sigin      measured signal, asynchronous to clkin
//   freq_out   rising edges counted in the last completed window
//   freq_valid one-cycle pulse when freq_out (and freq_bcd) update
//   overflow   last completed window saturated the edge counter
//   busy       high while a gate window is in progress
//   freq_bcd   (FREQ_METER_BCD_EN only) 8 BCD digits of freq_out,
//              32'h99999999 when freq_out > 99999999
//
// Optional feature macro: FREQ_METER_BCD_EN adds freq_bcd and a sequential
// shift-add-3 converter; freq_valid then fires once the conversion is done.
module freq_meter #(
    parameter int unsigned GATE_CYCLES = 50000000,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             en,
    input  logic             sigin,
    output logic [CNT_W-1:0] freq_out,
    output logic             freq_valid,
    output logic             overflow,
    output logic             busy
`ifdef FREQ_METER_BCD_EN
    ,
    output logic [31:0]      freq_bcd
`endif
);

    localparam int unsigned      GW        = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {IDLE, GATE, LATCH} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             s1;
    logic             s2;
    logic             s3;
    logic             sig_edge;
    logic [GW-1:0]    gate_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic             sat;

    // Two-flop synchronizer, one more stage for the edge history, edge registered
    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            s3       <= 1'b0;
            sig_edge <= 1'b0;
        end else begin
            s1       <= sigin;
            s2       <= s1;
            s3       <= s2;
            sig_edge <= s2 & ~s3;
        end
    end

    // State register
    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; dropping en aborts a window in progress
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = GATE;
            GATE: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else if (gate_cnt == GATE_LAST) begin
                    state_nxt = LATCH;
                end
            end
            LATCH:   state_nxt = en ? GATE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Gate and edge counters, cleared on every entry into GATE
    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
        end else if (state_nxt == GATE && state != GATE) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
        end else if (state == GATE) begin
            gate_cnt <= gate_cnt + GW'(1);
            if (sig_edge) begin
                if (edge_cnt == CNT_MAX) begin
                    sat <= 1'b1;
                end else begin
                    edge_cnt <= edge_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Result registers and busy
    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            freq_out <= '0;
            overflow <= 1'b0;
            busy     <= 1'b0;
        end else begin
            busy <= (state_nxt == GATE);
            if (state == LATCH) begin
                freq_out <= edge_cnt;
                overflow <= sat;
            end
        end
    end

`ifdef FREQ_METER_BCD_EN
    localparam int unsigned    CW        = (CNT_W > 1) ? $clog2(CNT_W) : 1;
    localparam logic [CW-1:0]  CONV_LAST = CW'(CNT_W - 1);

    logic [CNT_W-1:0] bin_sh;
    logic [31:0]      bcd_sh;
    logic [31:0]      bcd_adj;
    logic [31:0]      bcd_step;
    logic [CW-1:0]    conv_cnt;
    logic             conv_run;
    logic             big;

    // Add 3 to every digit >= 5 before the next shift
    always_comb begin
        bcd_adj = bcd_sh;
        for (int i = 0; i < 8; i++) begin
            if (bcd_sh[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_sh[4*i +: 4] + 4'd3;
            end
        end
    end

    assign bcd_step = {bcd_adj[30:0], bin_sh[CNT_W-1]};

    // Shift-add-3 converter, restarted by every LATCH
    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            bin_sh     <= '0;
            bcd_sh     <= '0;
            conv_cnt   <= '0;
            conv_run   <= 1'b0;
            big        <= 1'b0;
            freq_bcd   <= '0;
            freq_valid <= 1'b0;
        end else begin
            freq_valid <= 1'b0;
            if (state == LATCH) begin
                bin_sh   <= edge_cnt;
                bcd_sh   <= '0;
                conv_cnt <= '0;
                conv_run <= 1'b1;
                big      <= 64'(edge_cnt) > 64'd99999999;
            end else if (conv_run) begin
                bcd_sh   <= bcd_step;
                bin_sh   <= {bin_sh[CNT_W-2:0], 1'b0};
                conv_cnt <= conv_cnt + CW'(1);
                if (conv_cnt == CONV_LAST) begin
                    conv_run   <= 1'b0;
                    freq_bcd   <= big ? 32'h99999999 : bcd_step;
                    freq_valid <= 1'b1;
                end
            end
        end
    end
`else
    // Result pulse in the cycle after LATCH
    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            freq_valid <= 1'b0;
        end else begin
            freq_valid <= (state == LATCH);
        end
    end
`endif

endmodule
